// File: rtl/alu_issue_controller.sv
// alu_issue_controller
//
// Multi-cycle issue stage in front of a purely combinational ALU. It accepts
// one 16-bit instruction per valid/ready handshake and walks it through
// IDLE -> DECODE -> EXEC -> WB. It sources operands from a small register
// file, captures the ALU result, and writes it back to rd.
//
// Instruction word: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   instr_valid/ready   instruction handshake; ready is high only in IDLE
//   instr               instruction word, latched on the accept edge
//   alu_add..alu_clr    one-hot ALU operation strobes (EXEC and WB)
//   alu_in1, alu_in2    ALU operands (EXEC and WB)
//   alu_out, alu_overflow  ALU result inputs, captured at end of EXEC
//   done, illegal_op    one-cycle pulses during WB
//   overflow_flag       status flag updated at writeback
//   dbg_sel, dbg_data   combinational debug read of the register file
//
// Optional feature: define ALU_STICKY_OVERFLOW_EN to make overflow_flag
// sticky. It is set by any arithmetic overflow and cleared only by reset
// or by a CLR instruction.
module alu_issue_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [15:0]           instr,
  output logic                  alu_add,
  output logic                  alu_sub,
  output logic                  alu_and,
  output logic                  alu_or,
  output logic                  alu_xor,
  output logic                  alu_inv,
  output logic                  alu_clr,
  output logic [DATA_WIDTH-1:0] alu_in1,
  output logic [DATA_WIDTH-1:0] alu_in2,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_overflow,
  output logic                  done,
  output logic                  illegal_op,
  output logic                  overflow_flag,
  input  logic [1:0]            dbg_sel,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_INV  = 4'h6;
  localparam logic [3:0] OP_CLR  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_SUBI = 4'hA;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_t;

  state_t                state;
  logic [15:0]           instr_p0;    // instruction latched at accept
  logic [6:0]            strobe_p1;   // {add,sub,and,or,xor,inv,clr}
  logic [DATA_WIDTH-1:0] result_p2;   // ALU result captured at end of EXEC
  logic                  ovf_p2;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [3:0]            opcode;
  logic [1:0]            rd;
  logic [1:0]            rs;
  logic [DATA_WIDTH-1:0] imm;

  assign opcode = instr_p0[15:12];
  assign rd     = instr_p0[11:10];
  assign rs     = instr_p0[9:8];
  assign imm    = DATA_WIDTH'(instr_p0[7:0]);

  assign {alu_add, alu_sub, alu_and, alu_or, alu_xor, alu_inv, alu_clr} = strobe_p1;
  assign dbg_data = regs[dbg_sel];

  function automatic logic [6:0] decode_strobes(input logic [3:0] op);
    case (op)
      OP_ADD, OP_ADDI: decode_strobes = 7'b100_0000;
      OP_SUB, OP_SUBI: decode_strobes = 7'b010_0000;
      OP_AND:          decode_strobes = 7'b001_0000;
      OP_OR:           decode_strobes = 7'b000_1000;
      OP_XOR:          decode_strobes = 7'b000_0100;
      OP_INV:          decode_strobes = 7'b000_0010;
      OP_CLR:          decode_strobes = 7'b000_0001;
      default:         decode_strobes = 7'b000_0000;
    endcase
  endfunction

  function automatic logic is_arith(input logic [3:0] op);
    is_arith = (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) || (op == OP_SUBI);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    is_illegal = (op > OP_SUBI);
  endfunction

  // Every defined opcode except NOP writes rd.
  function automatic logic writes_reg(input logic [3:0] op);
    writes_reg = (op != OP_NOP) && !is_illegal(op);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      instr_ready   <= 1'b1;
      instr_p0      <= '0;
      strobe_p1     <= '0;
      alu_in1       <= '0;
      alu_in2       <= '0;
      result_p2     <= '0;
      ovf_p2        <= 1'b0;
      done          <= 1'b0;
      illegal_op    <= 1'b0;
      overflow_flag <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        // IDLE -> DECODE: latch the instruction on accept
        S_IDLE: begin
          if (instr_valid && instr_ready) begin
            instr_p0    <= instr;
            instr_ready <= 1'b0;
            state       <= S_DECODE;
          end
        end

        // DECODE -> EXEC: register strobes and operands; both read the
        // pre-instruction register values, so rd == rs is harmless
        S_DECODE: begin
          strobe_p1 <= decode_strobes(opcode);
          alu_in1   <= regs[rd];
          alu_in2   <= ((opcode == OP_ADDI) || (opcode == OP_SUBI)) ? imm : regs[rs];
          state     <= S_EXEC;
        end

        // EXEC -> WB: capture the ALU result and raise the WB pulses
        S_EXEC: begin
          result_p2  <= alu_out;
          ovf_p2     <= alu_overflow;
          done       <= 1'b1;
          illegal_op <= is_illegal(opcode);
          state      <= S_WB;
        end

        // WB -> IDLE: commit rd and the flag, drop strobes and operands
        S_WB: begin
          if (writes_reg(opcode)) begin
            regs[rd] <= (opcode == OP_LDI) ? imm : result_p2;
          end
`ifdef ALU_STICKY_OVERFLOW_EN
          if (opcode == OP_CLR) begin
            overflow_flag <= 1'b0;
          end else if (is_arith(opcode) && ovf_p2) begin
            overflow_flag <= 1'b1;
          end
`else
          if (is_arith(opcode)) begin
            overflow_flag <= ovf_p2;
          end else if (writes_reg(opcode)) begin
            overflow_flag <= 1'b0;
          end
`endif
          strobe_p1   <= '0;
          alu_in1     <= '0;
          alu_in2     <= '0;
          done        <= 1'b0;
          illegal_op  <= 1'b0;
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_controller.sv
// Testbench for alu_issue_controller. It holds a table of directed
// instructions with hand-computed results, followed by hand-written
// sequences for back-to-back issue and an asynchronous reset that lands
// mid-instruction. The ALU itself is modelled combinationally here. Its
// logic operations return only the low nibble, as the real unit does.
module tb_alu_issue_controller;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        alu_add, alu_sub, alu_and, alu_or, alu_xor, alu_inv, alu_clr;
  logic [7:0]  alu_in1, alu_in2;
  logic [7:0]  alu_out;
  logic        alu_overflow;
  logic        done, illegal_op, overflow_flag;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;

  int errors = 0;
  int checks = 0;

  alu_issue_controller #(.DATA_WIDTH(8), .NUM_REGS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .alu_add      (alu_add),
    .alu_sub      (alu_sub),
    .alu_and      (alu_and),
    .alu_or       (alu_or),
    .alu_xor      (alu_xor),
    .alu_inv      (alu_inv),
    .alu_clr      (alu_clr),
    .alu_in1      (alu_in1),
    .alu_in2      (alu_in2),
    .alu_out      (alu_out),
    .alu_overflow (alu_overflow),
    .done         (done),
    .illegal_op   (illegal_op),
    .overflow_flag(overflow_flag),
    .dbg_sel      (dbg_sel),
    .dbg_data     (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] strb;
  assign strb = {alu_add, alu_sub, alu_and, alu_or, alu_xor, alu_inv, alu_clr};

  // Combinational ALU model driven by the DUT strobes.
  always_comb begin
    alu_out      = 8'h00;
    alu_overflow = 1'b0;
    if (alu_add) begin
      {alu_overflow, alu_out} = {1'b0, alu_in1} + {1'b0, alu_in2};
    end else if (alu_sub) begin
      alu_out      = alu_in1 - alu_in2;
      alu_overflow = (alu_in1 < alu_in2);
    end else if (alu_and) begin
      alu_out = (alu_in1 & alu_in2) & 8'h0F;
    end else if (alu_or) begin
      alu_out = (alu_in1 | alu_in2) & 8'h0F;
    end else if (alu_xor) begin
      alu_out = (alu_in1 ^ alu_in2) & 8'h0F;
    end else if (alu_inv) begin
      alu_out = (~alu_in1) & 8'h0F;
    end
  end

  typedef struct {
    logic [15:0] w;       // instruction word
    logic [1:0]  sel;     // register to inspect afterwards
    logic [7:0]  val;     // expected register value
    logic        ovf;     // expected flag, per-instruction rules
    logic        ovf_s;   // expected flag, sticky build
    logic        ill;     // expected illegal_op in WB
    logic [6:0]  strb;    // expected strobes in EXEC/WB
    logic        chk_ops; // operands are meaningful for this op
    logic [7:0]  in1;
    logic [7:0]  in2;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic wait_ready(input string nm);
    int guard;
    guard = 0;
    while (!instr_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({nm, " ready-wait"}, instr_ready, 1);
  endtask

  // Issues one word and returns in IDLE, at 1 time unit after the WB->IDLE edge.
  task automatic issue(input logic [15:0] w);
    wait_ready("issue");
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    wait_ready(p);
    instr = v.w;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = 16'hFFFF;  // must be ignored while busy
    // DECODE
    chk({p, " decode ready"}, instr_ready, 0);
    chk({p, " decode done"}, done, 0);
    @(posedge clk); #1;
    // EXEC
    chk({p, " exec strobes"}, strb, v.strb);
    chk({p, " exec done"}, done, 0);
    if (v.chk_ops) begin
      chk({p, " exec in1"}, alu_in1, v.in1);
      chk({p, " exec in2"}, alu_in2, v.in2);
    end
    @(posedge clk); #1;
    // WB
    chk({p, " wb done"}, done, 1);
    chk({p, " wb illegal"}, illegal_op, v.ill);
    chk({p, " wb strobes"}, strb, v.strb);
    @(posedge clk); #1;
    // back in IDLE
    chk({p, " idle ready"}, instr_ready, 1);
    chk({p, " idle done"}, done, 0);
    chk({p, " idle illegal"}, illegal_op, 0);
    chk({p, " idle strobes"}, strb, 7'h00);
    dbg_sel = v.sel;
    #1;
    chk({p, " reg"}, dbg_data, v.val);
`ifdef ALU_STICKY_OVERFLOW_EN
    chk({p, " ovf"}, overflow_flag, v.ovf_s);
`else
    chk({p, " ovf"}, overflow_flag, v.ovf);
`endif
  endtask

  initial begin
    logic [15:0] bb [3];
    int acc_cyc [$];
    int low_cnt;
    int gap1, gap2;

    //            word      sel   val    ovf   ovf_s ill   strb    ops   in1    in2
    vecs[0]  = '{16'h8005, 2'd0, 8'h05, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 8'h00, 8'h00}; // LDI r0,05
    vecs[1]  = '{16'h8403, 2'd1, 8'h03, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 8'h00, 8'h00}; // LDI r1,03
    vecs[2]  = '{16'h2100, 2'd0, 8'h02, 1'b0, 1'b0, 1'b0, 7'h20, 1'b1, 8'h05, 8'h03}; // SUB r0,r1
    vecs[3]  = '{16'h8803, 2'd2, 8'h03, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 8'h00, 8'h00}; // LDI r2,03
    vecs[4]  = '{16'hA805, 2'd2, 8'hFE, 1'b1, 1'b1, 1'b0, 7'h20, 1'b1, 8'h03, 8'h05}; // SUBI r2,05
    vecs[5]  = '{16'h3A00, 2'd2, 8'h0E, 1'b0, 1'b1, 1'b0, 7'h10, 1'b1, 8'hFE, 8'hFE}; // AND r2,r2
    vecs[6]  = '{16'h8CF0, 2'd3, 8'hF0, 1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 8'h00, 8'h00}; // LDI r3,F0
    vecs[7]  = '{16'h9C20, 2'd3, 8'h10, 1'b1, 1'b1, 1'b0, 7'h40, 1'b1, 8'hF0, 8'h20}; // ADDI r3,20
    vecs[8]  = '{16'hC000, 2'd0, 8'h02, 1'b1, 1'b1, 1'b1, 7'h00, 1'b0, 8'h00, 8'h00}; // illegal
    vecs[9]  = '{16'h4400, 2'd1, 8'h03, 1'b0, 1'b1, 1'b0, 7'h08, 1'b1, 8'h03, 8'h02}; // OR r1,r0
    vecs[10] = '{16'h5500, 2'd1, 8'h00, 1'b0, 1'b1, 1'b0, 7'h04, 1'b1, 8'h03, 8'h03}; // XOR r1,r1
    vecs[11] = '{16'h6400, 2'd1, 8'h0F, 1'b0, 1'b1, 1'b0, 7'h02, 1'b0, 8'h00, 8'h00}; // INV r1
    vecs[12] = '{16'h1F00, 2'd3, 8'h20, 1'b0, 1'b1, 1'b0, 7'h40, 1'b1, 8'h10, 8'h10}; // ADD r3,r3
    vecs[13] = '{16'h7C00, 2'd3, 8'h00, 1'b0, 1'b0, 1'b0, 7'h01, 1'b0, 8'h00, 8'h00}; // CLR r3
    vecs[14] = '{16'h0000, 2'd3, 8'h00, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 8'h00, 8'h00}; // NOP

    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = 16'h0000;
    dbg_sel = 2'd0;

    // Reset values
    #12;
    chk("rst ready", instr_ready, 1);
    chk("rst strobes", strb, 7'h00);
    chk("rst in1", alu_in1, 8'h00);
    chk("rst in2", alu_in2, 8'h00);
    chk("rst done", done, 0);
    chk("rst illegal", illegal_op, 0);
    chk("rst ovf", overflow_flag, 0);
    for (int r = 0; r < 4; r++) begin
      dbg_sel = 2'(r);
      #1;
      chk($sformatf("rst reg%0d", r), dbg_data, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Back-to-back: valid held high, three instructions.
    bb[0] = 16'h8011;  // LDI r0,11
    bb[1] = 16'h8422;  // LDI r1,22
    bb[2] = 16'h1100;  // ADD r0,r1
    low_cnt = 0;
    instr = bb[0];
    instr_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (instr_ready) acc_cyc.push_back(c);
      else low_cnt++;
      @(posedge clk); #1;
      if (acc_cyc.size() < 3) instr = bb[acc_cyc.size()];
    end
    instr_valid = 1'b0;
    chk("b2b accepts", acc_cyc.size(), 3);
    gap1 = (acc_cyc.size() >= 2) ? acc_cyc[1] - acc_cyc[0] : -1;
    gap2 = (acc_cyc.size() >= 3) ? acc_cyc[2] - acc_cyc[1] : -1;
    chk("b2b gap1", gap1, 4);
    chk("b2b gap2", gap2, 4);
    chk("b2b ready-low cycles", low_cnt, 9);
    dbg_sel = 2'd0;
    #1;
    chk("b2b r0", dbg_data, 8'h33);
    dbg_sel = 2'd1;
    #1;
    chk("b2b r1", dbg_data, 8'h22);

    // Asynchronous reset during EXEC of ADD r0,r1.
    issue(16'h8011);  // LDI r0,11
    issue(16'h84F0);  // LDI r1,F0
    issue(16'h9420);  // ADDI r1,20 -> r1=10, flag 1
    chk("pre-rst ovf", overflow_flag, 1);
    wait_ready("abort");
    instr = 16'h1100;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort exec strobes", strb, 7'h40);
    #2;
    rst_n = 1'b0;
    #1;
    dbg_sel = 2'd0;
    #0;
    chk("abort strobes", strb, 7'h00);
    chk("abort ready", instr_ready, 1);
    chk("abort in1", alu_in1, 8'h00);
    chk("abort done", done, 0);
    chk("abort ovf", overflow_flag, 0);
    chk("abort r0", dbg_data, 8'h00);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("post-abort ready", instr_ready, 1);
    chk("post-abort r0", dbg_data, 8'h00);
    dbg_sel = 2'd1;
    #1;
    chk("post-abort r1", dbg_data, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
